// File: rtl/adder_tree_accum.sv
// Frame accumulator behind the registered adder tree: sums a programmable number of
// accepted beats into a saturating wide accumulator and presents the total on a valid/ready port.
module adder_tree_accum #(
    parameter int unsigned IN_WIDTH  = 21,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] frame_len,
    input  logic                 sync_clr,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_sum,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 overflow,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   r_len;
    logic [ACC_WIDTH-1:0]   r_out_sum;
    logic [CNT_WIDTH-1:0]   r_out_count;
    logic                   r_out_valid;
    logic                   r_overflow;

    logic                   w_beat;
    logic                   w_last;
    logic                   w_start_ok;
    logic [ACC_WIDTH:0]     w_sum_ext;
    logic                   w_carry;
    logic [ACC_WIDTH-1:0]   w_acc_nxt;

    assign w_beat     = (r_state == S_ACCUM) && in_valid;
    assign w_last     = (r_cnt == (r_len - CNT_ONE));
    assign w_start_ok = start && (frame_len != '0);

    // One extra bit on the add exposes the carry used for saturation.
    assign w_sum_ext  = {1'b0, r_acc} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, in_sum};
    assign w_carry    = w_sum_ext[ACC_WIDTH];
    assign w_acc_nxt  = w_carry ? '1 : w_sum_ext[ACC_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (sync_clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start_ok)           w_state_nxt = S_ACCUM;
                S_ACCUM: if (w_beat && w_last)     w_state_nxt = S_HOLD;
                S_HOLD:  if (out_ready)            w_state_nxt = S_IDLE;
                default:                           w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (r_state == S_ACCUM);
        busy     = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (sync_clr) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_len      <= frame_len;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt + CNT_ONE;
                        if (w_carry) begin
                            r_overflow <= 1'b1;
                        end
                        if (w_last) begin
                            r_out_sum   <= w_acc_nxt;
                            r_out_count <= r_len;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_adder_tree_accum.sv
// Directed bench for adder_tree_accum: a default 32-bit build and a 22-bit build
// share one stimulus stream so saturation is visible on the narrow instance.
module tb_adder_tree_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  frame_len = '0;
    logic        sync_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [20:0] in_sum = '0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_overflow, a_busy;
    logic [31:0] a_out_sum;
    logic [7:0]  a_out_count;
    logic        b_in_ready, b_out_valid, b_overflow, b_busy;
    logic [21:0] b_out_sum;
    logic [7:0]  b_out_count;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    adder_tree_accum #(.IN_WIDTH(21), .ACC_WIDTH(32), .CNT_WIDTH(8)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
        .sync_clr(sync_clr), .in_valid(in_valid), .in_sum(in_sum),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_sum(a_out_sum), .out_count(a_out_count), .overflow(a_overflow),
        .busy(a_busy)
    );

    adder_tree_accum #(.IN_WIDTH(21), .ACC_WIDTH(22), .CNT_WIDTH(8)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
        .sync_clr(sync_clr), .in_valid(in_valid), .in_sum(in_sum),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_sum(b_out_sum), .out_count(b_out_count), .overflow(b_overflow),
        .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic start_frame(input logic [7:0] len);
        start = 1'b1; frame_len = len;
        step(1);
        start = 1'b0; frame_len = '0;
    endtask

    task automatic send_beat(input logic [20:0] v);
        in_valid = 1'b1; in_sum = v;
        step(1);
        in_valid = 1'b0; in_sum = '0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [20:0] basic [4];
        basic[0] = 21'd100; basic[1] = 21'd200; basic[2] = 21'd300; basic[3] = 21'd400;

        // Reset state
        step(1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_sum",   a_out_sum, 0);
        chk("rst_out_count", a_out_count, 0);
        chk("rst_overflow",  a_overflow, 0);
        chk("rst_in_ready",  a_in_ready, 0);
        chk("rst_busy",      a_busy, 0);
        rst_n = 1'b1;
        step(1);

        // Basic frame
        start_frame(8'd4);
        chk("basic_in_ready", a_in_ready, 1);
        chk("basic_busy", a_busy, 1);
        for (int i = 0; i < 4; i++) begin
            chk("basic_no_valid_early", a_out_valid, 0);
            send_beat(basic[i]);
        end
        chk("basic_out_valid", a_out_valid, 1);
        chk("basic_out_sum", a_out_sum, 1000);
        chk("basic_out_count", a_out_count, 4);
        chk("basic_overflow", a_overflow, 0);
        chk("basic_hold_in_ready", a_in_ready, 0);
        handshake();
        chk("basic_done_valid", a_out_valid, 0);
        chk("basic_done_busy", a_busy, 0);
        step(1);

        // Gaps and backpressure
        start_frame(8'd3);
        send_beat(21'h1FFFFF); step(2);
        send_beat(21'h1FFFFF); step(2);
        chk("gap_no_valid", a_out_valid, 0);
        send_beat(21'h1FFFFF);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", a_out_valid, 1);
            chk("bp_out_sum", a_out_sum, 64'h5FFFFD);
            chk("bp_in_ready", a_in_ready, 0);
            step(1);
        end
        chk("bp_narrow_sat", b_out_sum, 64'h3FFFFF);
        chk("bp_narrow_ovf", b_overflow, 1);
        handshake();
        chk("bp_released", a_out_valid, 0);
        step(1);
        chk("bp_single_hs", a_out_valid, 0);
        chk("bp_idle", a_busy, 0);

        // Saturation on the 22-bit build, then a clean frame
        start_frame(8'd4);
        for (int i = 0; i < 4; i++) send_beat(21'h1FFFFF);
        chk("sat_out_sum", b_out_sum, 64'h3FFFFF);
        chk("sat_overflow", b_overflow, 1);
        chk("sat_wide_sum", a_out_sum, 64'h7FFFFC);
        chk("sat_wide_ovf", a_overflow, 0);
        handshake();
        step(1);
        start_frame(8'd2);
        send_beat(21'd5);
        send_beat(21'd5);
        chk("sat_next_sum", b_out_sum, 10);
        chk("sat_next_ovf", b_overflow, 0);
        handshake();
        step(1);

        // Ignored controls
        start_frame(8'd0);
        chk("len0_busy", a_busy, 0);
        start_frame(8'd2);
        send_beat(21'd11);
        start = 1'b1; frame_len = 8'd9;
        send_beat(21'd22);
        start = 1'b0; frame_len = '0;
        chk("midstart_valid", a_out_valid, 1);
        chk("midstart_count", a_out_count, 2);
        chk("midstart_sum", a_out_sum, 33);
        start = 1'b1; frame_len = 8'd3;
        handshake();
        start = 1'b0; frame_len = '0;
        chk("hs_start_ignored", a_busy, 0);

        // Abort, restart, async reset
        start_frame(8'd5);
        send_beat(21'd1);
        send_beat(21'd2);
        sync_clr = 1'b1;
        step(1);
        sync_clr = 1'b0;
        chk("clr_busy", a_busy, 0);
        chk("clr_in_ready", a_in_ready, 0);
        for (int i = 0; i < 6; i++) begin
            chk("clr_no_valid", a_out_valid, 0);
            step(1);
        end
        start_frame(8'd1);
        send_beat(21'd7);
        chk("one_beat_valid", a_out_valid, 1);
        chk("one_beat_sum", a_out_sum, 7);
        chk("one_beat_count", a_out_count, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", a_out_valid, 0);
        chk("arst_out_sum", a_out_sum, 0);
        chk("arst_busy", a_busy, 0);
        step(1);
        rst_n = 1'b1;
        step(1);

        // Maximum frame length
        start_frame(8'd255);
        in_valid = 1'b1; in_sum = 21'd1;
        step(255);
        chk("max_valid", a_out_valid, 1);
        chk("max_sum", a_out_sum, 255);
        chk("max_count", a_out_count, 255);
        chk("max_256th_not_ready", a_in_ready, 0);
        step(1);
        chk("max_sum_stable", a_out_sum, 255);
        in_valid = 1'b0; in_sum = '0;
        handshake();
        chk("max_done_busy", a_busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/adder_tree_accum.md
Name: adder_tree_accum

Overview:
- Downstream consumer of the registered adder-tree result.
- Accumulates a programmable-length frame of tree sums (one per accepted beat) into a wide accumulator.
- Presents the frame total, beat count and an overflow flag on a valid/ready output port.
- Sits between the adder-tree top (which produces `sum` each clock) and the result sink/readback logic.

Parameters:
- IN_WIDTH, 21, width of the unsigned tree sum (ADDER_WIDTH+1).
- ACC_WIDTH, 32, accumulator and output width; must be at least IN_WIDTH+1.
- CNT_WIDTH, 8, width of frame length and beat counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; in IDLE, latches frame_len and begins a frame.
- frame_len  in  CNT_WIDTH  number of beats per frame; sampled only on an accepted start.
- sync_clr  in  1  synchronous abort; highest priority after reset.
- in_valid  in  1  tree sum valid.
- in_sum  in  IN_WIDTH  unsigned tree sum.
- in_ready  out  1  block accepts in_sum this cycle.
- out_valid  out  1  frame result valid.
- out_ready  in  1  sink accepts the result.
- out_sum  out  ACC_WIDTH  frame total (saturated).
- out_count  out  CNT_WIDTH  beats accumulated in the frame.
- overflow  out  1  frame total saturated.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; acc, cnt, len, out_sum, out_count all 0; out_valid=0, overflow=0, in_ready=0, busy=0.
- FSM states: IDLE, ACCUM, HOLD. All outputs are registered or decoded from the state register; there is no combinational path from in_* or out_ready to any output.
- IDLE:
  - in_ready=0.
  - start=1 with frame_len!=0: len<=frame_len, acc<=0, cnt<=0, overflow<=0, go to ACCUM.
  - start=1 with frame_len==0: ignored, stay in IDLE.
- ACCUM:
  - in_ready=1.
  - Beat accepted when in_valid && in_ready.
  - On each beat: acc<=acc+zero-extend(in_sum), cnt<=cnt+1.
  - If the addition carries out of ACC_WIDTH: acc<=all ones, overflow<=1 (sticky for the frame). Later beats keep acc at all ones.
  - On the beat where cnt==len-1: next state HOLD, out_sum<=updated acc, out_count<=len, out_valid<=1 in the following cycle.
  - Latency: last accepted beat at cycle N gives out_valid=1 at cycle N+1.
  - in_valid=0 cycles: no change; gaps are allowed.
- HOLD:
  - in_ready=0.
  - out_valid=1; out_sum, out_count and overflow are stable until handshake.
  - On out_valid && out_ready: out_valid<=0, acc<=0, cnt<=0, go to IDLE.
  - A start arriving in the same cycle as the handshake is ignored; a new frame needs start while in IDLE.
  - Back-to-back frames therefore cost one IDLE cycle minimum.
- start while in ACCUM or HOLD: ignored; len is unchanged.
- sync_clr=1 in any state: next cycle state=IDLE; acc, cnt, out_valid, overflow all 0; any in-flight beat is discarded. sync_clr overrides start and a simultaneous handshake.
- frame_len = 2^CNT_WIDTH-1 (255) is the maximum frame. cnt never wraps, because the transition to HOLD happens at len-1.
- Width rule: in_sum is always unsigned zero-extended; the saturation compare uses an ACC_WIDTH+1-bit add.
- rst_n asserted mid-frame: immediate return to the reset values, independent of clk.

Test Plan:
- Basic frame: start with frame_len=4; beats 100, 200, 300, 400 on consecutive cycles -> out_valid=1 the cycle after the 4th beat, out_sum=1000, out_count=4, overflow=0; out_ready=1 -> IDLE next cycle, busy=0.
- Gaps and backpressure: frame_len=3; beats 0x1FFFFF ×3 with 2 idle cycles between each; out_ready held 0 for 5 cycles -> out_sum=0x5FFFFD stays stable while out_valid=1; in_ready=0 throughout HOLD; release out_ready -> single handshake.
- Saturation: ACC_WIDTH=22 build; frame_len=4; 4 × 0x1FFFFF -> out_sum=0x3FFFFF, overflow=1; the next frame of 2 × 5 -> out_sum=10, overflow=0.
- Ignored controls: start with frame_len=0 -> busy stays 0; start mid-frame with frame_len=9 while len=2 -> frame still ends after 2 beats with out_count=2.
- Abort and reset: sync_clr after 2 of 5 beats -> IDLE next cycle, out_valid never asserts; a new 1-beat frame with 7 -> out_sum=7. Then drop rst_n asynchronously mid-HOLD -> out_valid=0 and out_sum=0 immediately, before the next edge.
- Max length: frame_len=255, 255 beats of value 1 -> out_sum=255, out_count=255, no counter wrap; the 256th in_valid is not accepted (in_ready=0).
